eight_dot_product_multiply: RTL and testbench
=============================================

# eight_dot_product_multiply

Eight-lane single-precision floating-point dot-product engine for the conjugate-gradient emulator datapath. It multiplies two 8-element vector chunks lane by lane every clock and reduces the products through an adder tree. It accumulates the chunk sums over `ceil(NOE/8)` chunks and flags completion with `finish`. The matrix/vector wrapper instantiates it and feeds it one chunk pair per cycle from its row/vector memories.

## Interface
- `NOE`, default 16: number of valid elements (equations) in the dot product; ≥1.
- `WIDTH`, fixed at 32: element width in bits, IEEE-754 binary32.
- `LANES`, fixed at 8: elements per chunk.
- Derived: `CHUNKS = ceil(NOE/8)`.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low (0 = reset, sampled on the `clk` rising edge).
- `first_row_input` input 256: chunk of vector A; lane i in bits [255-32i : 224-32i], so lane 0 is the MSBs.
- `second_row_input` input 256: chunk of vector B, same lane packing.
- `result` output 32: accumulator value, binary32.
- `finish` output 1: high once the full dot product is in `result`.

## Operation
- Chunk counter `k` (0..CHUNKS) counts accepted chunks. While `k < CHUNKS`, each edge accepts the input pair and increments `k`.
- Masking: in chunk index c (0-based), lane i is valid iff `8c+i < NOE`. Invalid lanes contribute +0 regardless of input data.
- Stage 1: register `p[i] = A[i]*B[i]` for each lane.
- Stage 2: register `s = ((p0+p1)+(p2+p3))+((p4+p5)+(p6+p7))`. The tree order is fixed.
- Stage 3: `acc = acc + s`. `result = acc` at all times.
- Pipeline valid bits accompany each stage. Only valid stage-2 data updates `acc`.
- FP rules for all multiplies and adds:
  - Round toward zero.
  - Subnormal inputs and results flush to +0.
  - Overflow produces ±Inf (0x7F800000 / 0xFF800000).
  - Any NaN input, Inf*0, or Inf+(-Inf) produces 0x7FC00000.
  - An exact-zero sum is +0.
- After the last chunk is accumulated, `finish` rises and stays high. From then on inputs are ignored and `result` is frozen until reset.

## Timing
- Reset (`reset=0` at an edge): `k=0`, all pipeline registers and valid bits cleared, `acc=0x00000000`, `result=0`, `finish=0`.
- Edge 1 is the first edge with `reset=1`. Chunk j (1..CHUNKS) is sampled at edge j. Its products are registered at edge j, its tree sum at edge j+1, and it is accumulated at edge j+2.
- `finish` goes high at edge CHUNKS+2, the same edge the final accumulation lands. Latency is CHUNKS+2 cycles (NOE=16 → edge 4).
- `result` shows partial sums before `finish`. It is valid only while `finish=1`.
- There is no input handshake. The source must present chunk j during the cycle before edge j.
- Reset mid-operation discards all partial state. The next run starts over at edge 1 after release.
- NOE a multiple of 8: no lanes are masked. NOE<8: CHUNKS=1 and lanes ≥NOE are masked.

## Test plan
- NOE=16, every lane A=1.0 (0x3F800000), B=2.0 (0x40000000) → `result`=0x42000000 (32.0); `finish` 0 through edge 3, 1 at edge 4.
- NOE=16, chunk1 A=1.0 B=1.0, chunk2 A=-1.0 (0xBF800000) B=1.0 → `result`=0x00000000, `finish` at edge 4.
- NOE=12, A=B=1.0 in all 16 lanes including the padding → `result`=0x41400000 (12.0); lanes 4–7 of chunk 2 are masked.
- NOE=8, lane 0 A=0x7F800000 (Inf) B=0, other lanes 1.0 → 0x7FC00000. Separate run: lane 0 A=0x7F7FFFFF B=2.0, others 0 → 0x7F800000; `finish` at edge 3 in both.
- NOE=16, drive `reset=0` at edge 2, release, replay the first scenario → `finish`/`result` read 0 while in reset, then 0x42000000 with `finish` at the 4th edge after release.
- After `finish`, change inputs to random values for 10 cycles → `result` and `finish` unchanged.

Source files
------------

// File: rtl/eight_dot_product_multiply.sv
// Eight-lane binary32 dot-product engine: lane multiply, fixed-order adder
// tree, and chunk accumulator. Round toward zero, subnormals flush to +0.
module eight_dot_product_multiply #(
    parameter int NOE   = 16,
    parameter int WIDTH = 32,
    parameter int LANES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] first_row_input,
    input  logic [LANES*WIDTH-1:0] second_row_input,
    output logic [WIDTH-1:0]       result,
    output logic                   finish
);

    localparam int CHUNKS = (NOE + 7) / 8;
    localparam int KW     = $clog2(CHUNKS + 1) + 1;
    localparam logic [KW-1:0] CHUNKS_K   = KW'(CHUNKS);
    localparam logic [KW-1:0] LAST_CHUNK = KW'(CHUNKS - 1);
    localparam logic [31:0]   QNAN       = 32'h7FC00000;

    // binary32 multiply: RTZ, flush-to-zero, canonical NaN.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sr;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] prod;
        logic signed [10:0] er;
        logic [22:0] fr;
        logic [31:0] r;
        sr     = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        er     = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        fr     = prod[45:23];
        r      = 32'h00000000;
        if (prod[47]) begin
            er = er + 11'sd1;
            fr = prod[46:24];
        end else begin
            fr = prod[45:23];
        end
        if (a_nan || b_nan) begin
            r = QNAN;
        end else if (a_inf || b_inf) begin
            r = (a_zero || b_zero) ? QNAN : {sr, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            r = 32'h00000000;
        end else if (er >= 11'sd255) begin
            r = {sr, 8'hFF, 23'd0};
        end else if (er <= 11'sd0) begin
            r = 32'h00000000;
        end else begin
            r = {sr, er[7:0], fr};
        end
        return r;
    endfunction

    // binary32 add: RTZ using guard/round/sticky alignment, flush-to-zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0] big, sml, r;
        logic [7:0]  d;
        logic [26:0] m_big, m_sml, m_sh, dif, norm;
        logic [27:0] sum;
        logic signed [10:0] er;
        int          lz;
        logic        found;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d     = big[30:23] - sml[30:23];
        m_big = {1'b1, big[22:0], 3'b000};
        m_sml = {1'b1, sml[22:0], 3'b000};
        if (d >= 8'd27) begin
            m_sh = 27'd1;
        end else begin
            m_sh = (m_sml >> d) | {26'd0, |(m_sml & ((27'd1 << d) - 27'd1))};
        end
        sum   = {1'b0, m_big} + {1'b0, m_sh};
        dif   = m_big - m_sh;
        lz    = 0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && dif[i]) begin
                lz    = 26 - i;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        norm = dif << lz;
        er   = $signed({3'b000, big[30:23]});
        r    = 32'h00000000;
        if (a_nan || b_nan) begin
            r = QNAN;
        end else if (a_inf && b_inf && (a[31] != b[31])) begin
            r = QNAN;
        end else if (a_inf) begin
            r = a;
        end else if (b_inf) begin
            r = b;
        end else if (a_zero && b_zero) begin
            r = 32'h00000000;
        end else if (a_zero) begin
            r = b;
        end else if (b_zero) begin
            r = a;
        end else if (a[31] == b[31]) begin
            if (sum[27]) begin
                er = er + 11'sd1;
                r  = (er >= 11'sd255) ? {big[31], 8'hFF, 23'd0} : {big[31], er[7:0], sum[26:4]};
            end else begin
                r = {big[31], big[30:23], sum[25:3]};
            end
        end else if (dif == 27'd0) begin
            r = 32'h00000000;
        end else begin
            er = er - 11'(lz);
            r  = (er <= 11'sd0) ? 32'h00000000 : {big[31], er[7:0], norm[25:3]};
        end
        return r;
    endfunction

    logic [KW-1:0]   k_r;
    logic [KW-1:0]   done_cnt_r;
    logic [31:0]     prod_r [LANES];
    logic [31:0]     prod_s [LANES];
    logic            v1_r, v2_r;
    logic [31:0]     sum_r, sum_s;
    logic [31:0]     acc_r;
    logic            finish_r;
    logic            accept_s;

    // Masked lane products for the chunk presented this cycle.
    always_comb begin
        accept_s = (k_r < CHUNKS_K) && !finish_r;
        for (int i = 0; i < LANES; i++) begin
            prod_s[i] = 32'h00000000;
            if ((int'(k_r) * 8 + i) < NOE) begin
                prod_s[i] = fp_mul(first_row_input[LANES*WIDTH-1-32*i -: 32],
                                   second_row_input[LANES*WIDTH-1-32*i -: 32]);
            end else begin
                prod_s[i] = 32'h00000000;
            end
        end
    end

    // Fixed-order adder tree over the registered products.
    always_comb begin
        sum_s = fp_add(fp_add(fp_add(prod_r[0], prod_r[1]), fp_add(prod_r[2], prod_r[3])),
                       fp_add(fp_add(prod_r[4], prod_r[5]), fp_add(prod_r[6], prod_r[7])));
    end

    // Pipeline, chunk counting, accumulation and completion flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            k_r        <= '0;
            done_cnt_r <= '0;
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            sum_r      <= 32'h00000000;
            acc_r      <= 32'h00000000;
            finish_r   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_r[i] <= 32'h00000000;
            end
        end else begin
            v1_r <= accept_s;
            if (accept_s) begin
                k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
                for (int i = 0; i < LANES; i++) begin
                    prod_r[i] <= prod_s[i];
                end
            end else begin
                k_r <= k_r;
            end
            v2_r  <= v1_r;
            sum_r <= v1_r ? sum_s : sum_r;
            if (v2_r && !finish_r) begin
                acc_r      <= fp_add(acc_r, sum_r);
                done_cnt_r <= done_cnt_r + {{(KW-1){1'b0}}, 1'b1};
                finish_r   <= (done_cnt_r == LAST_CHUNK);
            end else begin
                acc_r      <= acc_r;
                done_cnt_r <= done_cnt_r;
                finish_r   <= finish_r;
            end
        end
    end

    assign result = acc_r;
    assign finish = finish_r;

endmodule

// File: tb/tb_eight_dot_product_multiply.sv
// Directed bench for eight_dot_product_multiply with NOE=16, 12 and 8.
module tb_eight_dot_product_multiply;

    logic         clk;
    logic         reset;
    logic [255:0] a_in, b_in;
    logic [31:0]  res16, res12, res8;
    logic         fin16, fin12, fin8;
    int           total;
    int           bad;
    logic [31:0]  hold_res;

    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] TWO  = 32'h40000000;
    localparam logic [31:0] MONE = 32'hBF800000;

    eight_dot_product_multiply #(.NOE(16)) dut16 (
        .clk(clk), .reset(reset), .first_row_input(a_in), .second_row_input(b_in),
        .result(res16), .finish(fin16));
    eight_dot_product_multiply #(.NOE(12)) dut12 (
        .clk(clk), .reset(reset), .first_row_input(a_in), .second_row_input(b_in),
        .result(res12), .finish(fin12));
    eight_dot_product_multiply #(.NOE(8)) dut8 (
        .clk(clk), .reset(reset), .first_row_input(a_in), .second_row_input(b_in),
        .result(res8), .finish(fin8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        check_val("rst_fin", {31'd0, fin16}, 32'd0);
        check_val("rst_res", res16, 32'h00000000);
        reset = 1'b1;
    endtask

    task automatic rand_in();
        for (int i = 0; i < 8; i++) begin
            a_in[32*i +: 32] = $urandom;
            b_in[32*i +: 32] = $urandom;
        end
    endtask

    task automatic scen_ones_twos(input string tag);
        a_in = {8{ONE}};
        b_in = {8{TWO}};
        tick();
        check_val({tag, "_f1"}, {31'd0, fin16}, 32'd0);
        tick();
        rand_in();
        check_val({tag, "_f2"}, {31'd0, fin16}, 32'd0);
        tick();
        check_val({tag, "_f3"}, {31'd0, fin16}, 32'd0);
        check_val({tag, "_part"}, res16, 32'h41800000);
        tick();
        check_val({tag, "_f4"}, {31'd0, fin16}, 32'd1);
        check_val({tag, "_res"}, res16, 32'h42000000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // 1) 16 x (1.0*2.0) = 32.0, then inputs ignored after finish
        do_reset();
        scen_ones_twos("s1");
        hold_res = res16;
        for (int c = 0; c < 10; c++) begin
            rand_in();
            tick();
        end
        check_val("hold_res", res16, hold_res);
        check_val("hold_fin", {31'd0, fin16}, 32'd1);

        // 2) +8 then -8 cancels to +0; NOE=12 run uses padding lanes of 1.0
        do_reset();
        a_in = {8{ONE}};
        b_in = {8{ONE}};
        tick();
        a_in = {8{MONE}};
        tick();
        tick();
        tick();
        check_val("s2_fin", {31'd0, fin16}, 32'd1);
        check_val("s2_res", res16, 32'h00000000);

        // 3) NOE=12, all ones including padding -> 12.0
        do_reset();
        a_in = {8{ONE}};
        b_in = {8{ONE}};
        tick();
        tick();
        tick();
        check_val("s3_f3", {31'd0, fin12}, 32'd0);
        tick();
        check_val("s3_fin", {31'd0, fin12}, 32'd1);
        check_val("s3_res", res12, 32'h41400000);

        // 4) NOE=8, Inf*0 in lane 0 -> canonical NaN
        do_reset();
        a_in = {32'h7F800000, {7{ONE}}};
        b_in = {32'h00000000, {7{ONE}}};
        tick();
        tick();
        check_val("s4_f2", {31'd0, fin8}, 32'd0);
        tick();
        check_val("s4_fin", {31'd0, fin8}, 32'd1);
        check_val("s4_res", res8, 32'h7FC00000);

        // 5) NOE=8, max_normal*2 overflows to +Inf
        do_reset();
        a_in = {32'h7F7FFFFF, {7{32'h00000000}}};
        b_in = {TWO, {7{32'h00000000}}};
        tick();
        tick();
        tick();
        check_val("s5_fin", {31'd0, fin8}, 32'd1);
        check_val("s5_res", res8, 32'h7F800000);

        // 6) reset mid-run, then replay scenario 1
        do_reset();
        a_in = {8{ONE}};
        b_in = {8{TWO}};
        tick();
        reset = 1'b0;
        tick();
        check_val("s6_rfin", {31'd0, fin16}, 32'd0);
        check_val("s6_rres", res16, 32'h00000000);
        tick();
        reset = 1'b1;
        scen_ones_twos("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
